burst_memory: RTL and testbench

Parametrised cell-array memory for the coprocessor, succeeding the single-beat block memory. It keeps the fixed config cell at address 0 and status cell at address 1, with a dedicated status write port. It adds multi-beat bursts, per-cell write masks, read backpressure and modulo-size address wrap-around. It sits between the coprocessor control FSM and the datapath, and moves `blocks` cells per beat.

---
 rtl/burst_memory.sv | 170 +++++++++++++++++
 tb/tb_burst_memory.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_memory.sv
// burst_memory: cell-array memory with multi-beat read/write bursts,
// per-cell write masks, read backpressure, modulo-size address wrap,
// a fixed config cell (0) and a status cell (1) with its own write port.
module burst_memory #(
  parameter int size       = 1024,
  parameter int log_size   = 10,
  parameter int cell_width = 32,
  parameter int blocks     = 4,
  parameter int log_burst  = 3,
  parameter int width      = blocks * cell_width
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_req,
  input  logic                  in_we,
  input  logic [log_size-1:0]   in_address,
  input  logic [log_burst-1:0]  in_len,
  output logic                  out_ready,
  input  logic [width-1:0]      in_data,
  input  logic [blocks-1:0]     in_mask,
  input  logic                  in_wvalid,
  output logic                  out_wready,
  output logic [width-1:0]      out_data,
  output logic                  out_rvalid,
  output logic                  out_rlast,
  input  logic                  in_rready,
  input  logic [cell_width-1:0] in_status,
  input  logic                  in_write_status_en,
  output logic [cell_width-1:0] out_status,
  output logic [cell_width-1:0] out_config
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t                state_q, state_d;
  logic [log_size-1:0]   base_q, base_d;
  // one extra bit so "all beats issued" is representable after the last beat
  logic [log_burst:0]    beat_q, beat_d;
  logic [log_burst-1:0]  len_q, len_d;
  logic [width-1:0]      out_data_q, out_data_d;
  logic                  out_rvalid_q, out_rvalid_d;
  logic                  out_rlast_q, out_rlast_d;

  logic [cell_width-1:0] mem_q [size];

  logic [log_size-1:0]   cell_addr [blocks];
  logic [blocks-1:0]     cell_we;
  logic                  accept;
  logic                  beats_left;
  logic                  load;
  logic                  rd_done;
  logic                  wr_beat;
  logic                  wr_last;

  // Address of each cell of the current beat; wraps by natural overflow
  always_comb begin
    for (int unsigned k = 0; k < blocks; k++) begin
      cell_addr[k] = base_q + log_size'(beat_q) * log_size'(blocks) + log_size'(k);
    end
  end

  // Handshake and progress qualifiers shared by FSM and datapath
  always_comb begin
    accept     = in_req & (state_q == IDLE);
    beats_left = (beat_q <= {1'b0, len_q});
    load       = (state_q == READ) & beats_left & (~out_rvalid_q | in_rready);
    rd_done    = (state_q == READ) & out_rvalid_q & in_rready & out_rlast_q;
    wr_beat    = (state_q == WRITE) & in_wvalid;
    wr_last    = wr_beat & (beat_q == {1'b0, len_q});
    for (int unsigned k = 0; k < blocks; k++) begin
      cell_we[k] = wr_beat & in_mask[k];
    end
  end

  // FSM state register
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = in_we ? WRITE : READ;
      READ:    if (rd_done) state_d = IDLE;
      WRITE:   if (wr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    out_ready  = (state_q == IDLE);
    out_wready = (state_q == WRITE);
  end

  // Burst bookkeeping and read beat register next values
  always_comb begin
    base_d       = base_q;
    len_d        = len_q;
    beat_d       = beat_q;
    out_data_d   = out_data_q;
    out_rvalid_d = out_rvalid_q;
    out_rlast_d  = out_rlast_q;
    if (accept) begin
      base_d = in_address;
      len_d  = in_len;
      beat_d = '0;
    end
    if (load || wr_beat) begin
      beat_d = beat_q + 1'b1;
    end
    // a new beat may replace an accepted one on the same edge
    if (load) begin
      for (int unsigned k = 0; k < blocks; k++) begin
        out_data_d[k*cell_width +: cell_width] = mem_q[cell_addr[k]];
      end
      out_rvalid_d = 1'b1;
      out_rlast_d  = (beat_q == {1'b0, len_q});
    end else if (out_rvalid_q && in_rready) begin
      out_rvalid_d = 1'b0;
      out_rlast_d  = 1'b0;
    end
  end

  // Burst bookkeeping and read beat registers
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      base_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      out_data_q   <= '0;
      out_rvalid_q <= 1'b0;
      out_rlast_q  <= 1'b0;
    end else begin
      base_q       <= base_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      out_data_q   <= out_data_d;
      out_rvalid_q <= out_rvalid_d;
      out_rlast_q  <= out_rlast_d;
    end
  end

  // Cell array; the status port is applied last so it wins over a beat on cell 1
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      for (int unsigned i = 0; i < size; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < blocks; k++) begin
        if (cell_we[k]) mem_q[cell_addr[k]] <= in_data[k*cell_width +: cell_width];
      end
      if (in_write_status_en) mem_q[1] <= in_status;
    end
  end

  assign out_data   = out_data_q;
  assign out_rvalid = out_rvalid_q;
  assign out_rlast  = out_rlast_q;
  assign out_config = mem_q[0];
  assign out_status = mem_q[1];

endmodule

// File: tb/tb_burst_memory.sv
// tb_burst_memory: directed bursts against a cell-array model with a
// per-cycle compare process and literal expectations for key beats.
module tb_burst_memory;

  localparam int SIZE = 1024;
  localparam int LS   = 10;
  localparam int CW   = 32;
  localparam int BL   = 4;
  localparam int LB   = 3;
  localparam int W    = BL * CW;

  logic          clk;
  logic          in_reset;
  logic          in_req;
  logic          in_we;
  logic [LS-1:0] in_address;
  logic [LB-1:0] in_len;
  logic          out_ready;
  logic [W-1:0]  in_data;
  logic [BL-1:0] in_mask;
  logic          in_wvalid;
  logic          out_wready;
  logic [W-1:0]  out_data;
  logic          out_rvalid;
  logic          out_rlast;
  logic          in_rready;
  logic [CW-1:0] in_status;
  logic          in_write_status_en;
  logic [CW-1:0] out_status;
  logic [CW-1:0] out_config;

  burst_memory #(
    .size(SIZE), .log_size(LS), .cell_width(CW),
    .blocks(BL), .log_burst(LB), .width(W)
  ) dut (
    .in_clk(clk), .in_reset(in_reset), .in_req(in_req), .in_we(in_we),
    .in_address(in_address), .in_len(in_len), .out_ready(out_ready),
    .in_data(in_data), .in_mask(in_mask), .in_wvalid(in_wvalid),
    .out_wready(out_wready), .out_data(out_data), .out_rvalid(out_rvalid),
    .out_rlast(out_rlast), .in_rready(in_rready), .in_status(in_status),
    .in_write_status_en(in_write_status_en), .out_status(out_status),
    .out_config(out_config)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] model_mem [SIZE];
  beat_t         exp_q [$];
  logic          m_idle = 1'b1;
  logic          m_wr   = 1'b0;
  logic [W-1:0]  wb_data [8];
  logic [BL-1:0] wb_mask [8];
  logic [W-1:0]  cap_data [8];
  logic          rv_hist [16];
  logic          rl_hist [16];
  int            hs_count;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int cell_index(input int base, input int b, input int k);
    return (base + b * BL + k) % SIZE;
  endfunction

  // per-cycle compare against the model, sampled on the falling edge
  beat_t        cmp_e;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  initial begin
    forever begin
      @(negedge clk);
      if (in_reset) begin
        prev_stall = 1'b0;
      end else begin
        chk("out_ready", W'(out_ready), W'(m_idle));
        chk("out_wready", W'(out_wready), W'(m_wr));
        chk("out_status", W'(out_status), W'(model_mem[1]));
        chk("out_config", W'(out_config), W'(model_mem[0]));
        if (prev_stall) begin
          chk("stall_data", out_data, prev_data);
          chk("stall_valid", W'(out_rvalid), W'(1'b1));
          chk("stall_last", W'(out_rlast), W'(prev_last));
        end
        if (out_rvalid && in_rready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data %h expected no beat", out_data);
          end else begin
            cmp_e = exp_q.pop_front();
            chk("read_data", out_data, cmp_e.data);
            chk("read_last", W'(out_rlast), W'(cmp_e.last));
          end
        end
        prev_stall = out_rvalid && !in_rready;
        prev_data  = out_data;
        prev_last  = out_rlast;
      end
    end
  end

  // entered and left at 2 time units after a rising edge
  task automatic do_write(input int addr, input int len, input int gap_beat,
                          input int st_beat, input logic [CW-1:0] st_val);
    in_req     = 1'b1;
    in_we      = 1'b1;
    in_address = LS'(addr);
    in_len     = LB'(len);
    @(posedge clk);
    m_idle = 1'b0;
    m_wr   = 1'b1;
    #2 in_req = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (b == gap_beat) begin
        in_wvalid = 1'b0;
        in_data   = '1;
        in_mask   = '1;
        @(posedge clk);
        #2;
      end
      in_wvalid          = 1'b1;
      in_data            = wb_data[b];
      in_mask            = wb_mask[b];
      in_write_status_en = (b == st_beat);
      in_status          = st_val;
      @(posedge clk);
      for (int k = 0; k < BL; k++) begin
        if (wb_mask[b][k]) model_mem[cell_index(addr, b, k)] = wb_data[b][k*CW +: CW];
      end
      if (b == st_beat) model_mem[1] = st_val;
      if (b == len) begin
        m_idle = 1'b1;
        m_wr   = 1'b0;
      end
      #2;
    end
    in_wvalid          = 1'b0;
    in_write_status_en = 1'b0;
  endtask

  task automatic do_read(input int addr, input int len, input int stall_beat, input int stall_cycles);
    beat_t e;
    int    hs;
    int    cyc;
    int    stall;
    logic  pre_v;
    logic  pre_r;
    for (int b = 0; b <= len; b++) begin
      e.data = '0;
      for (int k = 0; k < BL; k++) e.data[k*CW +: CW] = model_mem[cell_index(addr, b, k)];
      e.last = (b == len);
      exp_q.push_back(e);
    end
    in_req     = 1'b1;
    in_we      = 1'b0;
    in_address = LS'(addr);
    in_len     = LB'(len);
    in_rready  = 1'b1;
    @(posedge clk);
    m_idle = 1'b0;
    #2 in_req = 1'b0;
    hs    = 0;
    cyc   = 0;
    stall = 0;
    while (hs <= len && cyc < 64) begin
      pre_v = out_rvalid;
      pre_r = in_rready;
      @(posedge clk);
      cyc++;
      if (pre_v && pre_r) hs++;
      if (hs > len) m_idle = 1'b1;
      #1;
      if (cyc <= 16) begin
        rv_hist[cyc-1] = out_rvalid;
        rl_hist[cyc-1] = out_rlast;
      end
      if (out_rvalid && hs < 8) cap_data[hs] = out_data;
      #1;
      if (hs == stall_beat && stall < stall_cycles && out_rvalid) begin
        in_rready = 1'b0;
        stall++;
      end else begin
        in_rready = 1'b1;
      end
    end
    if (hs <= len) begin
      checks++;
      failures++;
      $display("FAIL read_timeout: got %0d beats expected %0d", hs, len + 1);
      m_idle = 1'b1;
    end
    hs_count = hs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SIZE; i++) model_mem[i] = '0;
    in_reset = 1'b1;
    in_req = 1'b0; in_we = 1'b0; in_address = '0; in_len = '0;
    in_data = '0; in_mask = '0; in_wvalid = 1'b0; in_rready = 1'b0;
    in_status = '0; in_write_status_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rvalid", W'(out_rvalid), W'(1'b0));
    chk("rst_rlast", W'(out_rlast), W'(1'b0));
    chk("rst_data", out_data, '0);
    chk("rst_ready", W'(out_ready), W'(1'b1));
    chk("rst_wready", W'(out_wready), W'(1'b0));
    chk("rst_status", W'(out_status), W'(32'h0));
    chk("rst_config", W'(out_config), W'(32'h0));
    in_reset = 1'b0;

    // two-beat write then read of the same shape at address 8
    wb_data[0] = 128'h00000003_00000002_00000001_00000000;
    wb_data[1] = 128'h00000007_00000006_00000005_00000004;
    wb_mask[0] = 4'hF;
    wb_mask[1] = 4'hF;
    do_write(8, 1, -1, -1, '0);
    do_read(8, 1, -1, 0);
    chk("lat_rvalid_t1", W'(rv_hist[0]), W'(1'b1));
    chk("lat_rvalid_t2", W'(rv_hist[1]), W'(1'b1));
    chk("lat_rlast_t1", W'(rl_hist[0]), W'(1'b0));
    chk("lat_rlast_t2", W'(rl_hist[1]), W'(1'b1));
    chk("rd8_beat0", cap_data[0], 128'h00000003_00000002_00000001_00000000);
    chk("rd8_beat1", cap_data[1], 128'h00000007_00000006_00000005_00000004);

    // burst straddling the top of the array
    wb_data[0] = 128'h00000103_00000102_00000101_00000100;
    wb_data[1] = 128'h00000107_00000106_00000105_00000104;
    do_write(1020, 1, -1, -1, '0);
    chk("wrap_config", W'(out_config), W'(32'h104));
    chk("wrap_status", W'(out_status), W'(32'h105));
    do_read(1020, 1, -1, 0);
    chk("wrap_beat1", cap_data[1], 128'h00000107_00000106_00000105_00000104);

    // masked write over a known background
    wb_data[0] = {4{32'hAAAAAAAA}};
    wb_mask[0] = 4'hF;
    do_write(32, 0, -1, -1, '0);
    wb_data[0] = 128'h00000033_00000032_00000031_00000030;
    wb_mask[0] = 4'b0101;
    do_write(32, 0, -1, -1, '0);
    do_read(32, 0, -1, 0);
    chk("mask_beat", cap_data[0], 128'hAAAAAAAA_00000032_AAAAAAAA_00000030);

    // four-beat read with beat 1 stalled for three cycles
    do_read(8, 3, 1, 3);
    chk("bp_beats", W'(hs_count), W'(4));
    chk("bp_beat1", cap_data[1], 128'h00000007_00000006_00000005_00000004);

    // maximum-length read wrapping through address 0
    do_read(1016, 7, -1, 0);
    chk("max_rvalid_t8", W'(rv_hist[7]), W'(1'b1));
    chk("max_rlast_t7", W'(rl_hist[6]), W'(1'b0));
    chk("max_rlast_t8", W'(rl_hist[7]), W'(1'b1));
    chk("max_beat1", cap_data[1], 128'h00000103_00000102_00000101_00000100);
    chk("max_beat2", cap_data[2], 128'h00000107_00000106_00000105_00000104);

    // write with a one-cycle valid gap before beat 1
    wb_data[0] = 128'h0000A003_0000A002_0000A001_0000A000;
    wb_data[1] = 128'h0000B003_0000B002_0000B001_0000B000;
    wb_data[2] = 128'h0000C003_0000C002_0000C001_0000C000;
    wb_mask[0] = 4'hF;
    wb_mask[1] = 4'b1011;
    wb_mask[2] = 4'hF;
    do_write(40, 2, 1, -1, '0);
    do_read(40, 2, -1, 0);
    chk("gap_beat1", cap_data[1], 128'h0000B003_00000000_0000B001_0000B000);

    // beat writes cell 1 while the status port writes it on the same edge
    wb_data[0] = 128'h00000044_00000033_00000011_000000F0;
    wb_mask[0] = 4'hF;
    do_write(0, 0, -1, 0, 32'h22);
    chk("coll_status", W'(out_status), W'(32'h22));
    chk("coll_config", W'(out_config), W'(32'hF0));
    do_read(0, 0, -1, 0);

    // asynchronous reset in the middle of a stalled read burst
    in_req = 1'b1; in_we = 1'b0; in_address = LS'(8); in_len = LB'(3); in_rready = 1'b0;
    @(posedge clk);
    m_idle = 1'b0;
    #2 in_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 in_reset = 1'b1;
    m_idle = 1'b1;
    m_wr   = 1'b0;
    for (int i = 0; i < SIZE; i++) model_mem[i] = '0;
    exp_q.delete();
    #1;
    chk("mid_rst_rvalid", W'(out_rvalid), W'(1'b0));
    chk("mid_rst_rlast", W'(out_rlast), W'(1'b0));
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_ready", W'(out_ready), W'(1'b1));
    chk("mid_rst_status", W'(out_status), W'(32'h0));
    chk("mid_rst_config", W'(out_config), W'(32'h0));
    @(posedge clk);
    #2 in_reset = 1'b0;
    in_rready = 1'b1;
    do_read(8, 1, -1, 0);
    chk("post_rst_beat0", cap_data[0], '0);
    do_read(1020, 1, -1, 0);
    chk("post_rst_wrap", cap_data[1], '0);

    repeat (3) @(posedge clk);
    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
